// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/DM unified-memory arbiter.
// Optional feature macro (used by mem_port_arbiter): MEM_ARB_PERF_CNT_EN.
package mem_arb_pkg;

   localparam int ADDR_W_DEF     = 32;
   localparam int DATA_W_DEF     = 32;
   localparam int CTRL_W_DEF     = 3;
   localparam int MAX_DM_RUN_DEF = 4;
   localparam int RUN_CNT_W      = 4;

   localparam logic [2:0] CTRL_WORD = 3'b010;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2
   } arb_state_t;

   typedef enum logic {
      OWN_IF = 1'b0,
      OWN_DM = 1'b1
   } owner_t;

   function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v,
                                                    input logic [RUN_CNT_W-1:0] lim);
      return (v >= lim) ? lim : v + 1'b1;
   endfunction

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the shared memory port: DM first, unless IF has waited
// through MAX_DM_RUN consecutive DM grants.
module mem_arb_prio
   import mem_arb_pkg::*;
#(
   parameter int MAX_DM_RUN = MAX_DM_RUN_DEF
) (
   input  logic clk,
   input  logic reset,
   input  logic if_req_i,
   input  logic dm_req_i,
   input  logic accept_i,
   output logic if_gnt_o,
   output logic dm_gnt_o
);

   localparam logic [RUN_CNT_W-1:0] RUN_LIM = RUN_CNT_W'(MAX_DM_RUN);

   logic [RUN_CNT_W-1:0] run_cnt_q;
   logic [RUN_CNT_W-1:0] run_cnt_d;
   logic                 starve;

   always_comb begin
      starve   = if_req_i && (run_cnt_q == RUN_LIM);
      dm_gnt_o = accept_i && dm_req_i && !starve;
      if_gnt_o = accept_i && if_req_i && !dm_gnt_o;

      // The run only measures DM grants taken while IF is actually waiting.
      run_cnt_d = run_cnt_q;
      if (!if_req_i || if_gnt_o) begin
         run_cnt_d = '0;
      end else if (dm_gnt_o) begin
         run_cnt_d = sat_inc(run_cnt_q, RUN_LIM);
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         run_cnt_q <= '0;
      end else begin
         run_cnt_q <= run_cnt_d;
      end
   end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and data memory.
// Define MEM_ARB_PERF_CNT_EN to add the IF-wait and DM-grant perf counters.
module mem_port_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int DATA_W     = DATA_W_DEF,
   parameter int CTRL_W     = CTRL_W_DEF,
   parameter int MAX_DM_RUN = MAX_DM_RUN_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              if_req_i,
   input  logic [ADDR_W-1:0] if_addr_i,
   output logic              if_gnt_o,
   output logic [DATA_W-1:0] if_rdata_o,
   output logic              if_rvalid_o,
   input  logic              dm_req_i,
   input  logic              dm_we_i,
   input  logic [ADDR_W-1:0] dm_addr_i,
   input  logic [DATA_W-1:0] dm_wdata_i,
   input  logic [CTRL_W-1:0] dm_ctrl_i,
   output logic              dm_gnt_o,
   output logic [DATA_W-1:0] dm_rdata_o,
   output logic              dm_rvalid_o,
   output logic              mem_req_o,
   output logic              mem_we_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_wdata_o,
   output logic [CTRL_W-1:0] mem_ctrl_o,
   input  logic              mem_ready_i,
`ifdef MEM_ARB_PERF_CNT_EN
   output logic [31:0]       perf_if_wait_o,
   output logic [31:0]       perf_dm_grants_o,
`endif
   input  logic [DATA_W-1:0] mem_rdata_i
);

   arb_state_t        state_q, state_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [CTRL_W-1:0] mem_ctrl_q, mem_ctrl_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_rvalid_q, if_rvalid_d;
   logic              dm_rvalid_q, dm_rvalid_d;

   logic   accept;
   logic   done;
   owner_t win_own;

   // A new request may only be taken while the port is free or finishing.
   assign accept  = (state_q == IDLE) || mem_ready_i;
   assign done    = (state_q != IDLE) && mem_ready_i;
   assign win_own = dm_gnt_o ? OWN_DM : OWN_IF;

   mem_arb_prio #(
      .MAX_DM_RUN (MAX_DM_RUN)
   ) u_prio (
      .clk      (clk),
      .reset    (reset),
      .if_req_i (if_req_i),
      .dm_req_i (dm_req_i),
      .accept_i (accept),
      .if_gnt_o (if_gnt_o),
      .dm_gnt_o (dm_gnt_o)
   );

   always_comb begin
      state_d     = state_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      mem_ctrl_d  = mem_ctrl_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      if_rvalid_d = done && (state_q == BUSY_IF);
      dm_rvalid_d = done && (state_q == BUSY_DM);

      if (if_rvalid_d) if_rdata_d = mem_rdata_i;
      if (dm_rvalid_d) dm_rdata_d = mem_rdata_i;

      if (if_gnt_o || dm_gnt_o) begin
         mem_req_d = 1'b1;
         if (win_own == OWN_DM) begin
            state_d     = BUSY_DM;
            mem_we_d    = dm_we_i;
            mem_addr_d  = dm_addr_i;
            mem_wdata_d = dm_wdata_i;
            mem_ctrl_d  = dm_ctrl_i;
         end else begin
            state_d     = BUSY_IF;
            mem_we_d    = 1'b0;
            mem_addr_d  = if_addr_i;
            mem_wdata_d = '0;
            mem_ctrl_d  = CTRL_W'(CTRL_WORD);
         end
      end else if (done) begin
         state_d   = IDLE;
         mem_req_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         mem_ctrl_q  <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_rvalid_q <= 1'b0;
         dm_rvalid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         mem_ctrl_q  <= mem_ctrl_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_rvalid_q <= if_rvalid_d;
         dm_rvalid_q <= dm_rvalid_d;
      end
   end

   assign mem_req_o   = mem_req_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_ctrl_o  = mem_ctrl_q;
   assign if_rdata_o  = if_rdata_q;
   assign dm_rdata_o  = dm_rdata_q;
   assign if_rvalid_o = if_rvalid_q;
   assign dm_rvalid_o = dm_rvalid_q;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] perf_if_wait_q, perf_if_wait_d;
   logic [31:0] perf_dm_grants_q, perf_dm_grants_d;

   always_comb begin
      perf_if_wait_d   = perf_if_wait_q + {31'd0, (if_req_i && !if_gnt_o)};
      perf_dm_grants_d = perf_dm_grants_q + {31'd0, dm_gnt_o};
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_if_wait_q   <= '0;
         perf_dm_grants_q <= '0;
      end else begin
         perf_if_wait_q   <= perf_if_wait_d;
         perf_dm_grants_q <= perf_dm_grants_d;
      end
   end

   assign perf_if_wait_o   = perf_if_wait_q;
   assign perf_dm_grants_o = perf_dm_grants_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized checks of mem_port_arbiter against a transaction-level model.
module tb_mem_port_arbiter;
   import mem_arb_pkg::*;

   localparam int AW   = 32;
   localparam int DW   = 32;
   localparam int CW   = 3;
   localparam int MAXR = 4;

   logic          clk = 1'b0;
   logic          reset;
   logic          if_req, dm_req, dm_we, mem_ready;
   logic [AW-1:0] if_addr, dm_addr;
   logic [DW-1:0] dm_wdata, mem_rdata;
   logic [CW-1:0] dm_ctrl;
   logic          if_gnt_o, if_rvalid_o, dm_gnt_o, dm_rvalid_o;
   logic [DW-1:0] if_rdata_o, dm_rdata_o, mem_wdata_o;
   logic          mem_req_o, mem_we_o;
   logic [AW-1:0] mem_addr_o;
   logic [CW-1:0] mem_ctrl_o;
`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0]   perf_if_wait_o, perf_dm_grants_o;
   int            sc_wait, sc_dmg;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(
      .ADDR_W(AW), .DATA_W(DW), .CTRL_W(CW), .MAX_DM_RUN(MAXR)
   ) dut (
      .clk(clk), .reset(reset),
      .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt_o),
      .if_rdata_o(if_rdata_o), .if_rvalid_o(if_rvalid_o),
      .dm_req_i(dm_req), .dm_we_i(dm_we), .dm_addr_i(dm_addr),
      .dm_wdata_i(dm_wdata), .dm_ctrl_i(dm_ctrl), .dm_gnt_o(dm_gnt_o),
      .dm_rdata_o(dm_rdata_o), .dm_rvalid_o(dm_rvalid_o),
      .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
      .mem_wdata_o(mem_wdata_o), .mem_ctrl_o(mem_ctrl_o),
      .mem_ready_i(mem_ready),
`ifdef MEM_ARB_PERF_CNT_EN
      .perf_if_wait_o(perf_if_wait_o), .perf_dm_grants_o(perf_dm_grants_o),
`endif
      .mem_rdata_i(mem_rdata)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic nxt();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_idle();
      if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
      dm_wdata = '0; dm_ctrl = '0; mem_ready = 0; mem_rdata = '0;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      drive_idle();
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;
   endtask

   // Transaction-level reference state for the random phase
   int          own;      // 0 none, 1 IF, 2 DM
   int          run;
   logic        p_we;
   logic [2:0]  p_ctrl;
   logic [31:0] p_addr, p_wdata;
   logic        e_ifv, e_dmv;
   logic [31:0] e_ifd, e_dmd;
   logic        win, eg_dm, eg_if, done;

   initial begin
      drive_idle();
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst_mem_ctl", {mem_req_o, mem_we_o, mem_ctrl_o}, 0);
      chk("rst_mem_addr_data", {mem_addr_o, mem_wdata_o}, 0);
      chk("rst_rvalid", {if_rvalid_o, dm_rvalid_o}, 0);
      chk("rst_rdata", {if_rdata_o, dm_rdata_o}, 0);
      chk("rst_state", dut.state_q, IDLE);
      nxt();
      reset = 1'b0;

      // IF-only fetch
      if_req = 1; if_addr = 32'h100;
      @(negedge clk);
      chk("if_gnt_c0", {if_gnt_o, dm_gnt_o}, 2'b10);
      nxt();
      if_req = 0; mem_ready = 1; mem_rdata = 32'h00500093;
      @(negedge clk);
      chk("if_mem_req_c1", mem_req_o, 1);
      chk("if_mem_addr_c1", mem_addr_o, 32'h100);
      chk("if_mem_we_ctrl_c1", {mem_we_o, mem_ctrl_o}, {1'b0, 3'b010});
      chk("if_rvalid_c1", if_rvalid_o, 0);
      nxt();
      mem_ready = 0; mem_rdata = '0;
      @(negedge clk);
      chk("if_rvalid_c2", if_rvalid_o, 1);
      chk("if_rdata_c2", if_rdata_o, 32'h00500093);
      chk("if_mem_req_c2", mem_req_o, 0);
      nxt();
      @(negedge clk);
      chk("if_rvalid_c3", if_rvalid_o, 0);
      nxt();

      // Simultaneous DM read and IF fetch, back-to-back
      dm_req = 1; dm_we = 0; dm_addr = 32'h2000; dm_ctrl = 3'b010;
      if_req = 1; if_addr = 32'h104;
      @(negedge clk);
      chk("sim_gnt_c0", {if_gnt_o, dm_gnt_o}, 2'b01);
      nxt();
      dm_req = 0; mem_ready = 1; mem_rdata = 32'h11112222;
      @(negedge clk);
      chk("sim_if_gnt_c1", {if_gnt_o, dm_gnt_o}, 2'b10);
      chk("sim_mem_c1", {mem_req_o, mem_addr_o}, {1'b1, 32'h2000});
      nxt();
      if_req = 0; mem_rdata = 32'h33334444;
      @(negedge clk);
      chk("sim_b2b_mem_c2", {mem_req_o, mem_addr_o}, {1'b1, 32'h104});
      chk("sim_dm_rvalid_c2", {dm_rvalid_o, dm_rdata_o}, {1'b1, 32'h11112222});
      nxt();
      mem_ready = 0;
      @(negedge clk);
      chk("sim_if_rvalid_c3", {if_rvalid_o, if_rdata_o}, {1'b1, 32'h33334444});
      chk("sim_dm_quiet_c3", {dm_rvalid_o, mem_req_o, dm_rdata_o}, {2'b00, 32'h11112222});
      nxt();

      // DM write with three wait cycles
      dm_req = 1; dm_we = 1; dm_addr = 32'h3000; dm_wdata = 32'hDEADBEEF; dm_ctrl = 3'b001;
      @(negedge clk);
      chk("wr_gnt", dm_gnt_o, 1);
      for (int c = 1; c <= 4; c++) begin
         nxt();
         dm_req = 0; dm_we = 0; dm_wdata = '0; dm_ctrl = '0; mem_ready = (c == 4);
         @(negedge clk);
         chk("wr_hold_ctl", {mem_req_o, mem_we_o, mem_ctrl_o}, {2'b11, 3'b001});
         chk("wr_hold_addr_data", {mem_addr_o, mem_wdata_o}, {32'h3000, 32'hDEADBEEF});
         chk("wr_no_early_rvalid", dm_rvalid_o, 0);
      end
      nxt();
      mem_ready = 0;
      @(negedge clk);
      chk("wr_rvalid", dm_rvalid_o, 1);
      chk("wr_if_rdata_kept", if_rdata_o, 32'h33334444);
      chk("wr_idle", mem_req_o, 0);
      nxt();
      @(negedge clk);
      chk("wr_rvalid_pulse_end", dm_rvalid_o, 0);
      nxt();

      // Asynchronous reset while BUSY_DM with memory stalled
      dm_req = 1; dm_we = 0; dm_addr = 32'h4000; dm_ctrl = 3'b010;
      @(negedge clk);
      chk("arst_gnt", dm_gnt_o, 1);
      nxt();
      dm_req = 0; mem_ready = 0;
      @(negedge clk);
      chk("arst_busy", {mem_req_o, dut.state_q}, {1'b1, BUSY_DM});
      #2 reset = 1'b1;
      #1;
      chk("arst_req_drop", mem_req_o, 0);
      chk("arst_state", dut.state_q, IDLE);
      nxt();
      reset = 1'b0; mem_ready = 1; mem_rdata = 32'hCAFE0001;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk("arst_no_rvalid", {dm_rvalid_o, if_rvalid_o, mem_req_o}, 0);
         nxt();
      end
      mem_ready = 0;

      // Anti-starvation: both requesters held, memory ready every cycle
      dm_req = 1; dm_we = 0; dm_addr = 32'h5000; dm_ctrl = 3'b010;
      if_req = 1; if_addr = 32'h200; mem_ready = 1; mem_rdata = 32'h0;
`ifdef MEM_ARB_PERF_CNT_EN
      sc_wait = 0; sc_dmg = 0;
`endif
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         chk("starve_gnt", {if_gnt_o, dm_gnt_o}, ((c % 5) == 4) ? 2'b10 : 2'b01);
         if (c > 0) chk("starve_no_bubble", mem_req_o, 1);
`ifdef MEM_ARB_PERF_CNT_EN
         chk("starve_perf_wait", perf_if_wait_o, sc_wait);
         chk("starve_perf_dmg", perf_dm_grants_o, sc_dmg);
         if ((c % 5) != 4) begin
            sc_wait++;
            sc_dmg++;
         end
`endif
         nxt();
      end
`ifdef MEM_ARB_PERF_CNT_EN
      @(negedge clk);
      chk("starve_perf_wait_end", perf_if_wait_o, sc_wait);
      chk("starve_perf_dmg_end", perf_dm_grants_o, sc_dmg);
`endif

      // Randomized traffic against the reference model
      do_reset();
      own = 0; run = 0; p_we = 0; p_ctrl = '0; p_addr = '0; p_wdata = '0;
      e_ifv = 0; e_dmv = 0; e_ifd = '0; e_dmd = '0;
`ifdef MEM_ARB_PERF_CNT_EN
      sc_wait = 0; sc_dmg = 0;
`endif
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         win   = (own == 0) || mem_ready;
         eg_dm = win && dm_req && !(if_req && run == MAXR);
         eg_if = win && if_req && !eg_dm;
         chk("rnd_gnt", {if_gnt_o, dm_gnt_o}, {eg_if, eg_dm});
         chk("rnd_mem_req", mem_req_o, own != 0);
         if (own != 0) chk("rnd_mem_payload", {mem_we_o, mem_ctrl_o, mem_addr_o}, {p_we, p_ctrl, p_addr});
         if (own == 2 && p_we) chk("rnd_mem_wdata", mem_wdata_o, p_wdata);
         chk("rnd_rvalid", {if_rvalid_o, dm_rvalid_o}, {e_ifv, e_dmv});
         chk("rnd_rdata", {if_rdata_o, dm_rdata_o}, {e_ifd, e_dmd});
`ifdef MEM_ARB_PERF_CNT_EN
         chk("rnd_perf", {perf_if_wait_o, perf_dm_grants_o}, {sc_wait[31:0], sc_dmg[31:0]});
         sc_wait += (if_req && !eg_if) ? 1 : 0;
         sc_dmg  += eg_dm ? 1 : 0;
`endif
         done  = (own != 0) && mem_ready;
         e_ifv = done && own == 1;
         e_dmv = done && own == 2;
         if (e_ifv) e_ifd = mem_rdata;
         if (e_dmv) e_dmd = mem_rdata;
         if (!if_req || eg_if) run = 0;
         else if (eg_dm) run = (run < MAXR) ? run + 1 : MAXR;
         if (eg_dm) begin
            own = 2; p_we = dm_we; p_ctrl = dm_ctrl; p_addr = dm_addr; p_wdata = dm_wdata;
         end else if (eg_if) begin
            own = 1; p_we = 0; p_ctrl = CTRL_WORD; p_addr = if_addr;
         end else if (done) begin
            own = 0;
         end
         nxt();
         if (!if_req || eg_if) begin
            if_req = ($urandom_range(0, 3) != 0); if_addr = $urandom;
         end
         if (!dm_req || eg_dm) begin
            dm_req = ($urandom_range(0, 2) != 0); dm_we = 1'($urandom_range(0, 1));
            dm_addr = $urandom; dm_wdata = $urandom; dm_ctrl = 3'($urandom_range(0, 7));
         end
         mem_ready = ($urandom_range(0, 2) != 0);
         mem_rdata = $urandom;
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported unified memory between the instruction-fetch (IF) and data-memory (DM) requesters of Pipelined_design.
- Sits between the core's fetch and MEM-stage ports and the external RAM.
- Arbitrates, registers the winning request and holds it until the memory acknowledges.
- Returns the read data and a one-cycle valid pulse to the owner; DM has priority, bounded by an IF anti-starvation limit.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- CTRL_W, 3, width of the access-type control (byte/half/word, signed/unsigned), passed through unchanged.
- MAX_DM_RUN, 4, maximum consecutive DM grants while IF is waiting; range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- if_req_i  in  1  fetch request; held with if_addr_i until if_gnt_o.
- if_addr_i  in  ADDR_W  fetch address.
- if_gnt_o  out  1  combinational grant; request is latched at this edge.
- if_rdata_o  out  DATA_W  fetched instruction.
- if_rvalid_o  out  1  one-cycle pulse; if_rdata_o valid.
- dm_req_i  in  1  data request; held with its payload until dm_gnt_o.
- dm_we_i  in  1  1 = write.
- dm_addr_i  in  ADDR_W  data address.
- dm_wdata_i  in  DATA_W  write data.
- dm_ctrl_i  in  CTRL_W  access type.
- dm_gnt_o  out  1  combinational grant.
- dm_rdata_o  out  DATA_W  read data.
- dm_rvalid_o  out  1  one-cycle completion pulse, for reads and writes.
- mem_req_o  out  1  registered memory request.
- mem_we_o  out  1  registered write enable.
- mem_addr_o  out  ADDR_W  registered address.
- mem_wdata_o  out  DATA_W  registered write data.
- mem_ctrl_o  out  CTRL_W  registered access type.
- mem_ready_i  in  1  memory accepted/completed the current request this cycle.
- mem_rdata_i  in  DATA_W  read data, valid when mem_ready_i = 1.

Behaviour:
- Reset values:
  - State IDLE.
  - All mem_* outputs 0.
  - if_rvalid_o, dm_rvalid_o 0; if_rdata_o, dm_rdata_o 0.
  - Run counter 0.
- States: IDLE, BUSY_IF, BUSY_DM.
- Accept window: state IDLE, or BUSY_x with mem_ready_i = 1.
  - Only inside the window may a grant assert; at most one grant per cycle.
- Arbitration inside the window:
  - DM wins if dm_req_i = 1 and not (if_req_i = 1 and run counter = MAX_DM_RUN).
  - Otherwise IF wins if if_req_i = 1.
  - Otherwise no grant.
- On a grant:
  - Payload is latched into mem_* with mem_req_o = 1 at the edge.
  - Next state is BUSY_DM or BUSY_IF.
  - IF requests drive mem_we_o = 0 and mem_ctrl_o = word encoding.
- Back-to-back operation: completion and a new grant in the same cycle keep mem_req_o high with no bubble. With no new grant → IDLE, mem_req_o = 0.
- While BUSY and mem_ready_i = 0: mem_* held stable.
- Completion (BUSY_x and mem_ready_i):
  - Owner's rdata register ← mem_rdata_i.
  - Owner's rvalid_o = 1 next cycle only.
  - The other requester's rdata is unchanged.
- Latency:
  - Grant in cycle 0; mem_req_o high from cycle 1.
  - mem_ready_i in cycle k ≥ 1; rvalid in cycle k+1.
  - Minimum request-to-rvalid latency is 2 cycles.
- Run counter:
  - +1 on a DM grant while if_req_i = 1, saturating at MAX_DM_RUN.
  - Cleared on an IF grant, or in any cycle with if_req_i = 0.
- mem_ready_i in IDLE is ignored.
- Async reset mid-transaction:
  - Immediately drops mem_req_o and aborts the transaction.
  - No rvalid is produced for the aborted access.

Optional Feature:
- Macro: MEM_ARB_PERF_CNT_EN.
- When defined, adds two 32-bit outputs, both reset to 0, both wrapping modulo 2^32:
  - perf_if_wait_o: counts cycles with if_req_i = 1 and if_gnt_o = 0.
  - perf_dm_grants_o: counts dm_gnt_o pulses.
- When undefined, these ports and their counters do not exist; all other behaviour is identical.

Decomposition:
- Package mem_arb_pkg:
  - arb_state_t enum {IDLE, BUSY_IF, BUSY_DM}.
  - owner_t enum {OWN_IF, OWN_DM}.
  - Constant CTRL_WORD = 3'b010.
  - Default widths.
- One sub-module, mem_arb_prio: combinational winner select plus run-counter register, taking req, accept-window and counter inputs.
- FSM and datapath registers stay in the top module.

Test Plan:
- Reset while BUSY_DM, memory holding mem_ready_i = 0 → mem_req_o drops asynchronously; no dm_rvalid_o after reset release; state IDLE.
- IF-only fetch: if_addr 0x100, mem_ready_i in cycle 1, mem_rdata_i = 0x00500093 → if_gnt_o in cycle 0, if_rvalid_o in cycle 2 with if_rdata_o = 0x00500093.
- Simultaneous requests in IDLE: DM read 0x2000, IF 0x104 → dm_gnt_o first; if_gnt_o in the same cycle as the DM completion (back-to-back, mem_req_o never drops).
- Starvation, MAX_DM_RUN = 4: dm_req_i and if_req_i held continuously, ready every cycle → grant sequence DM, DM, DM, DM, IF, DM, ...
- DM write 0xDEADBEEF to 0x3000 with ctrl 3'b001, ready after 3 wait cycles → mem_we_o = 1 and mem_ctrl_o = 3'b001 stable for all 4 cycles; dm_rvalid_o one-cycle pulse; if_rdata_o unchanged.
- Under MEM_ARB_PERF_CNT_EN, rerun the starvation scenario for 20 cycles → perf_if_wait_o and perf_dm_grants_o match the scoreboard counts exactly.
